nibble_framer: RTL

NIBBLE_FRAMER -- requirements
Module: nibble_framer

---
 rtl/nibble_framer_pkg.sv | 19 +
 rtl/nib_bank.sv | 54 +++++
 rtl/nibble_framer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nibble_framer_pkg.sv
// Shared definitions for the nibble framer: frame geometry, FSM states and
// the slot-index helper used by the control logic.
package nibble_framer_pkg;

  localparam int unsigned N_WORDS = 6;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // True when idx addresses the last slot of a frame.
  function automatic logic is_final_slot(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_WORDS - 1));
  endfunction

endpackage

// File: rtl/nib_bank.sv
// Six-slot frame register bank; one slot written per enabled cycle, slots
// hold their value otherwise and are only cleared by reset.
module nib_bank
  import nibble_framer_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     c,
  output logic [W-1:0]     d,
  output logic [W-1:0]     e,
  output logic [W-1:0]     f
);

  logic [W-1:0] a_q, b_q, c_q, d_q, e_q, f_q;

  // Slot storage; indices 6 and 7 never write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      e_q <= '0;
      f_q <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        3'd0:    a_q <= wr_data;
        3'd1:    b_q <= wr_data;
        3'd2:    c_q <= wr_data;
        3'd3:    d_q <= wr_data;
        3'd4:    e_q <= wr_data;
        3'd5:    f_q <= wr_data;
        default: a_q <= a_q;
      endcase
    end else begin
      a_q <= a_q;
    end
  end

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign d = d_q;
  assign e = e_q;
  assign f = f_q;

endmodule

// File: rtl/nibble_framer.sv
// Collects six serial words into a frame for the sorting network, rejecting
// short and over-long frames with a one-cycle err pulse.
module nibble_framer
  import nibble_framer_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [W-1:0] e,
  output logic [W-1:0] f,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err,
  output logic [7:0]   frame_cnt
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             wr_en;
  logic             accept;
  logic             xfer;

  // Handshake flags come from the state register alone.
  assign in_ready  = (state_q == FILL) || (state_q == DRAIN);
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  // Next-state, slot write and error decision.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (is_final_slot(idx_q)) begin
            idx_d = 3'd0;
            if (in_last) begin
              state_d = FULL;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (in_last) begin
            err_d = 1'b1;
            idx_d = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      FULL: begin
        if (xfer) begin
          state_d = FILL;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          state_d = FULL;
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          state_d = FILL;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= 3'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  nib_bank #(.W(W)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (in_data),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .e       (e),
    .f       (f)
  );

  assign err       = err_q;
  assign frame_cnt = cnt_q;

endmodule
